// File: rtl/alu_taylor_calc.sv
`default_nettype none
//==============================================================================
// Module      : alu_taylor_calc
// Description : Sequential Taylor-series evaluator. Walks the coefficient ROM
//               (a0 plus per-index derivative coefficients) and accumulates
//               the series for one signed Q1.16 argument using a single
//               shared 18x18 signed multiplier, two multiply cycles per term.
//               Optional build macro: ALU_TAYLOR_SAT_EN (saturating narrowing
//               and accumulation; wrap-around when undefined).
// Revision    : 1.0 - initial release
//==============================================================================
module alu_taylor_calc (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  function_sel,
   input  logic [17:0] x,
   output logic [2:0]  coef_func_sel,
   output logic [3:0]  coef_idx,
   input  logic [17:0] coef_deriv,
   input  logic [17:0] coef_a0,
   output logic        busy,
   output logic        done,
   output logic [17:0] result
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MUL_X = 3'd2,
      ST_MUL_C = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   // Captured operands and series working registers
   logic signed [17:0] x_reg;
   logic        [2:0]  func_reg;
   logic        [3:0]  idx;
   logic signed [17:0] term;
   logic signed [17:0] p_reg;
   logic signed [17:0] acc;
   logic        [17:0] result_reg;

   // Shared multiplier path
   logic signed [17:0] mul_a;
   logic signed [17:0] mul_b;
   logic signed [35:0] mul_prod;
   logic signed [35:0] mul_shift;
   logic signed [17:0] mul_narrow;
   logic signed [17:0] acc_sum;

   logic coef_zero;
   logic last_idx;

   assign coef_zero     = (coef_deriv == 18'd0);
   assign last_idx      = (idx == 4'd15);
   assign coef_func_sel = func_reg;
   assign coef_idx      = idx;
   assign result        = result_reg;

   // Operand select: term*x in MUL_X, p*coef in every other state
   always_comb begin
      mul_a = p_reg;
      mul_b = $signed(coef_deriv);
      if (state == ST_MUL_X) begin
         mul_a = term;
         mul_b = x_reg;
      end
   end

   // Full-precision signed product; the shift restores the operand's Q format
   assign mul_prod  = 36'(mul_a) * 36'(mul_b);
   assign mul_shift = (state == ST_MUL_X) ? (mul_prod >>> 16) : (mul_prod >>> 15);

`ifdef ALU_TAYLOR_SAT_EN
   logic signed [18:0] acc_wide;

   // Clamp the shifted product and the accumulator sum into 18 bits
   always_comb begin
      if (mul_shift[35:17] == {19{mul_shift[35]}}) begin
         mul_narrow = mul_shift[17:0];
      end else if (mul_shift[35]) begin
         mul_narrow = 18'sh20000;
      end else begin
         mul_narrow = 18'sh1FFFF;
      end

      acc_wide = {acc[17], acc} + {mul_narrow[17], mul_narrow};
      if (acc_wide[18] == acc_wide[17]) begin
         acc_sum = acc_wide[17:0];
      end else if (acc_wide[18]) begin
         acc_sum = 18'sh20000;
      end else begin
         acc_sum = 18'sh1FFFF;
      end
   end
`else
   logic unused_mul_hi;

   // Two's-complement wrap: keep the low 18 bits of product and sum
   assign mul_narrow    = mul_shift[17:0];
   assign acc_sum       = acc + mul_narrow;
   assign unused_mul_hi = ^mul_shift[35:18];
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and status outputs
   always_comb begin
      state_nxt = state;
      busy      = (state != ST_IDLE);
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nxt = ST_MUL_X;
         end
         ST_MUL_X: begin
            // A zero coefficient marks the end of the series
            state_nxt = coef_zero ? ST_DONE : ST_MUL_C;
         end
         ST_MUL_C: begin
            state_nxt = last_idx ? ST_DONE : ST_MUL_X;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: capture, series step and result update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_reg      <= '0;
         func_reg   <= '0;
         idx        <= '0;
         term       <= '0;
         p_reg      <= '0;
         acc        <= '0;
         result_reg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  x_reg    <= x;
                  func_reg <= function_sel;
                  idx      <= 4'd0;
               end
            end
            ST_LOAD: begin
               term <= coef_a0;
               acc  <= coef_a0;
            end
            ST_MUL_X: begin
               // Result is loaded on the way into DONE so it is valid with done
               if (coef_zero) begin
                  result_reg <= acc;
               end else begin
                  p_reg <= mul_narrow;
               end
            end
            ST_MUL_C: begin
               term <= mul_narrow;
               acc  <= acc_sum;
               if (last_idx) begin
                  result_reg <= acc_sum;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_taylor_calc.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_taylor_calc
// Description : Self-checking bench for alu_taylor_calc with a coefficient
//               ROM stub and a cycle-level expectation model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_taylor_calc;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  function_sel = 3'd0;
   logic [17:0] x = 18'd0;
   logic [2:0]  coef_func_sel;
   logic [3:0]  coef_idx;
   logic [17:0] coef_deriv;
   logic [17:0] coef_a0;
   logic        busy;
   logic        done;
   logic [17:0] result;

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   localparam logic [2:0] F_STUB = 3'd0;
   localparam logic [2:0] F_INV  = 3'd1;
   localparam logic [2:0] F_FULL = 3'd2;
   localparam logic [2:0] F_BAD  = 3'd7;

   alu_taylor_calc dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .function_sel (function_sel),
      .x            (x),
      .coef_func_sel(coef_func_sel),
      .coef_idx     (coef_idx),
      .coef_deriv   (coef_deriv),
      .coef_a0      (coef_a0),
      .busy         (busy),
      .done         (done),
      .result       (result)
   );

   always #5 clk = ~clk;

   // ROM stub contents
   function automatic logic [17:0] rom_coef(input logic [2:0] f, input logic [3:0] k);
      case (f)
         F_STUB:  return (k <= 4'd2)  ? 18'h08000 : 18'h00000;
         F_INV:   return (k <= 4'd10) ? 18'h38000 : 18'h00000;
         F_FULL:  return 18'h08000;
         default: return 18'h00000;
      endcase
   endfunction

   function automatic logic [17:0] rom_a0(input logic [2:0] f);
      return (f == F_STUB || f == F_INV || f == F_FULL) ? 18'h10000 : 18'h00000;
   endfunction

   always_comb begin
      coef_deriv = rom_coef(coef_func_sel, coef_idx);
      coef_a0    = rom_a0(coef_func_sel);
   end

   // Reference arithmetic on plain integers
   function automatic longint sx(input logic [17:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint narrow(input longint v);
`ifdef ALU_TAYLOR_SAT_EN
      if (v > 131071)  return 131071;
      if (v < -131072) return -131072;
      return v;
`else
      longint w;
      w = v & 64'h3FFFF;
      if (w >= 131072) w = w - 262144;
      return w;
`endif
   endfunction

   // want_n=1 returns the number of nonzero coefficients, else the sum
   function automatic longint series_eval(input logic [2:0] f, input logic [17:0] xv, input bit want_n);
      longint term, acc, p, xs, c, n;
      term = sx(rom_a0(f));
      acc  = term;
      xs   = sx(xv);
      n    = 0;
      for (int k = 0; k < 16; k++) begin
         c = sx(rom_coef(f, k[3:0]));
         if (c == 0) break;
         p    = narrow((term * xs) >>> 16);
         term = narrow((p * c) >>> 15);
         acc  = narrow(acc + term);
         n    = n + 1;
      end
      return want_n ? n : acc;
   endfunction

   function automatic int done_cycle_of(input logic [2:0] f, input logic [17:0] xv);
      int n;
      n = int'(series_eval(f, xv, 1'b1));
      return (n < 16) ? (2 * n + 3) : 34;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Expectation model: cycle position within a run, plus held result
   logic        m_active;
   int          m_cyc;
   int          m_done_cyc;
   logic [17:0] m_calc;
   logic [17:0] m_result;
   logic [2:0]  m_fsel;

   // Advance the model on each clock; reset clears it immediately
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active   <= 1'b0;
         m_cyc      <= 0;
         m_done_cyc <= 0;
         m_calc     <= '0;
         m_result   <= '0;
         m_fsel     <= '0;
      end else if (!m_active) begin
         if (start) begin
            m_active   <= 1'b1;
            m_cyc      <= 1;
            m_fsel     <= function_sel;
            m_calc     <= 18'(series_eval(function_sel, x, 1'b0));
            m_done_cyc <= done_cycle_of(function_sel, x);
         end
      end else begin
         if (m_cyc == m_done_cyc) begin
            m_active <= 1'b0;
         end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == m_done_cyc) m_result <= m_calc;
         end
      end
   end

   // Compare DUT outputs to the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_active));
         check("done", 32'(done), 32'(m_active && (m_cyc == m_done_cyc)));
         check("coef_func_sel", 32'(coef_func_sel), 32'(m_fsel));
         if (m_active && m_cyc < m_done_cyc)
            check("coef_idx", 32'(coef_idx), 32'((m_cyc < 2) ? 0 : (m_cyc - 2) / 2));
         if (!m_active || m_cyc == m_done_cyc)
            check("result", 32'(result), 32'(m_result));
      end
   end

   // One run: start pulse, wait for done, check latency and optional literal
   task automatic run(input logic [2:0] f, input logic [17:0] xv, input bit chk_res,
                      input logic [17:0] lit, input int lit_cyc, input bit extra);
      int c;
      @(negedge clk);
      function_sel = f;
      x            = xv;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      forever begin
         if (extra) start = (c == 3 || c == 9);
         if (done) break;
         if (c >= 60) break;
         @(negedge clk);
         c++;
      end
      check("done_cycle", 32'(c), 32'(lit_cyc));
      if (chk_res) check("result_literal", 32'(result), 32'(lit));
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_coef_idx", 32'(coef_idx), 32'd0);
      check("rst_coef_func_sel", 32'(coef_func_sel), 32'd0);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      run(F_STUB, 18'h08000, 1'b1, 18'h1E000, 9, 1'b0);
      run(F_INV,  18'h00000, 1'b1, 18'h10000, 25, 1'b0);
      run(F_INV,  18'h04000, 1'b0, 18'h00000, 25, 1'b0);
`ifdef ALU_TAYLOR_SAT_EN
      run(F_FULL, 18'h0C000, 1'b1, 18'h1FFFF, 34, 1'b0);
`else
      run(F_FULL, 18'h0C000, 1'b0, 18'h00000, 34, 1'b0);
`endif
      run(F_STUB, 18'h3C000, 1'b0, 18'h00000, 9, 1'b0);
      run(F_STUB, 18'h08000, 1'b1, 18'h1E000, 9, 1'b1);

      // Reset in the middle of a run
      @(negedge clk);
      function_sel = F_INV;
      x            = 18'h04000;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_coef_idx", 32'(coef_idx), 32'd0);
      check("midrst_coef_func_sel", 32'(coef_func_sel), 32'd0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run(F_STUB, 18'h08000, 1'b1, 18'h1E000, 9, 1'b0);
      run(F_BAD,  18'h08000, 1'b1, 18'h00000, 3, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
